// File: rtl/quickq_cmd_issuer.sv
// Client-side command issuer for the QuickQ priority-queue engine: one request in flight,
// occupancy tracking, full/empty rejection. Optional engine watchdog under QQ_CMD_TIMEOUT_EN.
module quickq_cmd_issuer #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH+1),
  parameter int TMO   = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_op,
  input  logic [DW-1:0] req_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          enq,
  output logic          deq,
  output logic [DW-1:0] eng_data,
  input  logic          eng_done,
  input  logic [DW-1:0] eng_rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        r_state, w_next;
  logic          r_op;
  logic [DW-1:0] r_key;
  logic [DW-1:0] r_rsp_data;
  logic          r_rsp_err;
  logic [CW-1:0] r_count;
  logic          w_reject;
  logic          w_tmo;

`ifdef QQ_CMD_TIMEOUT_EN
  localparam int WW = $clog2(TMO+1);
  logic [WW-1:0] r_wdog;

  // Fires on the TMO-th consecutive WAIT cycle without a completion.
  assign w_tmo = (r_state == WAIT) && !eng_done && (r_wdog == WW'(TMO-1));

  always_ff @(posedge clk) begin
    if (rst || r_state == ISSUE) r_wdog <= '0;
    else if (r_state == WAIT)    r_wdog <= r_wdog + 1'b1;
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TMO != 0);
  assign w_tmo        = 1'b0;
`endif

  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign w_reject = req_op ? empty : full;

  assign count     = r_count;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign eng_data  = r_key;
  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign enq       = (r_state == ISSUE) && !r_op;
  assign deq       = (r_state == ISSUE) &&  r_op;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = w_reject ? RESP : ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (eng_done || w_tmo) w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= 1'b0;
      r_key      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_count    <= '0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_op  <= req_op;
          r_key <= req_data;
          // Illegal ops never reach the engine, which keeps count within 0..DEPTH.
          if (w_reject) begin
            r_rsp_err  <= 1'b1;
            r_rsp_data <= '1;
          end
        end
        WAIT: begin
          if (eng_done) begin
            r_rsp_err  <= 1'b0;
            r_rsp_data <= r_op ? eng_rdata : r_key;
            r_count    <= r_op ? r_count - 1'b1 : r_count + 1'b1;
          end else if (w_tmo) begin
            r_rsp_err  <= 1'b1;
            r_rsp_data <= '1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quickq_cmd_issuer.sv
// Self-checking bench for quickq_cmd_issuer: directed and random requests against a
// priority-queue reference model (engine returns the smallest stored key on dequeue).
module tb_quickq_cmd_issuer;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_op;
  logic [DW-1:0] req_data;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_data;
  logic          enq, deq, eng_done, full, empty;
  logic [DW-1:0] eng_data, eng_rdata;
  logic [CW-1:0] count;

  quickq_cmd_issuer #(.DW(DW), .DEPTH(DEPTH), .TMO(255)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .enq(enq), .deq(deq), .eng_data(eng_data), .eng_done(eng_done), .eng_rdata(eng_rdata),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  logic [DW-1:0] q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_occ(input string tag);
    chk({tag, ".count"}, 64'(count), 64'(q.size()));
    chk({tag, ".full"},  64'(full),  64'(q.size() == DEPTH));
    chk({tag, ".empty"}, 64'(empty), 64'(q.size() == 0));
  endtask

  // One complete request/response exchange; the bench plays the engine.
  task automatic txn(input bit op, input logic [DW-1:0] key, input int dly,
                     input int hold, input bit done_in_issue);
    bit            rej;
    logic [DW-1:0] exp_d;
    int            mi;
    chk("idle.req_ready", 64'(req_ready), 64'(1));
    rej = op ? (q.size() == 0) : (q.size() == DEPTH);
    req_valid = 1'b1; req_op = op; req_data = key;
    tick();
    req_valid = 1'b0; req_data = $urandom;
    if (rej) begin
      exp_d = '1;
      chk("rej.enq", 64'(enq), 64'(0));
      chk("rej.deq", 64'(deq), 64'(0));
    end else begin
      chk("issue.enq", 64'(enq), 64'(!op));
      chk("issue.deq", 64'(deq), 64'(op));
      if (!op) chk("issue.eng_data", 64'(eng_data), 64'(key));
      chk("issue.rsp_valid", 64'(rsp_valid), 64'(0));
      chk("issue.req_ready", 64'(req_ready), 64'(0));
      if (op) begin
        mi = 0;
        foreach (q[i]) if (q[i] < q[mi]) mi = i;
        exp_d = q[mi];
        q.delete(mi);
        eng_rdata = exp_d;
      end else begin
        exp_d = key;
        q.push_back(key);
        eng_rdata = $urandom;
      end
      eng_done = done_in_issue;
      tick();
      eng_done = 1'b0;
      chk("wait.strobes", 64'({enq, deq}), 64'(0));
      chk("wait.rsp_valid", 64'(rsp_valid), 64'(0));
      for (int d = 0; d < dly; d++) begin
        tick();
        chk("wait.hold_rsp_valid", 64'(rsp_valid), 64'(0));
        if (!op) chk("wait.eng_data", 64'(eng_data), 64'(key));
      end
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      eng_rdata = $urandom;
    end
    chk("rsp.valid", 64'(rsp_valid), 64'(1));
    chk("rsp.err",   64'(rsp_err),   64'(rej));
    chk("rsp.data",  64'(rsp_data),  64'(exp_d));
    chk_occ("rsp");
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'($urandom); req_op = 1'($urandom); req_data = $urandom;
      eng_done = 1'($urandom);
      tick();
      eng_done = 1'b0;
      chk("hold.valid",     64'(rsp_valid), 64'(1));
      chk("hold.data",      64'(rsp_data),  64'(exp_d));
      chk("hold.err",       64'(rsp_err),   64'(rej));
      chk("hold.req_ready", 64'(req_ready), 64'(0));
      chk("hold.count",     64'(count),     64'(q.size()));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("post.rsp_valid", 64'(rsp_valid), 64'(0));
    chk("post.req_ready", 64'(req_ready), 64'(1));
    chk_occ("post");
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_data = '0;
    rsp_ready = 1'b0; eng_done = 1'b0; eng_rdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset.req_ready", 64'(req_ready), 64'(1));
    chk("reset.rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset.rsp_err",   64'(rsp_err),   64'(0));
    chk("reset.rsp_data",  64'(rsp_data),  64'(0));
    chk("reset.strobes",   64'({enq, deq}), 64'(0));
    chk("reset.eng_data",  64'(eng_data),  64'(0));
    chk_occ("reset");

    // Enqueue 5 with completion two cycles after the strobe, then drain it and underflow.
    txn(1'b0, 32'h5, 1, 0, 1'b0);
    txn(1'b1, 32'h0, 0, 0, 1'b0);
    txn(1'b1, 32'h0, 0, 0, 1'b0);

    // Fill to DEPTH, overflow, drain, underflow.
    for (int i = 0; i < DEPTH; i++)
      txn(1'b0, $urandom, $urandom_range(0, 2), 0, 1'($urandom));
    txn(1'b0, 32'hABCD, 0, 1, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      txn(1'b1, $urandom, $urandom_range(0, 2), $urandom_range(0, 1), 1'b0);
    txn(1'b1, 32'h0, 0, 0, 1'b0);

    // Smallest key comes back first; response held 5 cycles.
    txn(1'b0, 32'h9, 0, 0, 1'b0);
    txn(1'b0, 32'h3, 0, 0, 1'b0);
    txn(1'b0, 32'h7, 0, 0, 1'b0);
    txn(1'b1, 32'h0, 1, 5, 1'b0);

    // A stray completion while idle must not move the count.
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("stray.rsp_valid", 64'(rsp_valid), 64'(0));
    chk_occ("stray");

    for (int i = 0; i < 80; i++)
      txn(($urandom_range(0, 9) < 5), $urandom_range(0, 1000), $urandom_range(0, 3),
          $urandom_range(0, 2), 1'($urandom));

    // Reset while waiting on the engine drops the operation and clears occupancy.
    if (q.size() == DEPTH) txn(1'b1, 32'h0, 0, 0, 1'b0);
    req_valid = 1'b1; req_op = 1'b0; req_data = 32'h55;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    chk("rstwait.req_ready", 64'(req_ready), 64'(1));
    chk("rstwait.rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rstwait.strobes",   64'({enq, deq}), 64'(0));
    chk_occ("rstwait");
    tick();
    chk("rstwait.idle_valid", 64'(rsp_valid), 64'(0));
    txn(1'b0, 32'h11, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
